// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, grant hold, forced revoke
// after MAX_HOLD cycles under contention, and a one-cycle idle gap between grants.
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0]     HOLD_LIM = 8'(MAX_HOLD);
    // With forced revoke disabled the counter still saturates instead of wrapping.
    localparam logic [7:0]     HOLD_SAT = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);
    localparam logic [IDW:0]   N_EXT    = (IDW + 1)'(N);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;

    logic           sel_found;
    logic [IDW-1:0] sel_id;
    logic [IDW:0]   scan_sum;
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] next_ptr;
    logic           holder_req;
    logic           others_req;
    logic           revoke;

    // Scan upward from ptr with explicit modulo-N wrap so any N works.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (scan_sum >= N_EXT) begin
                scan_sum = scan_sum - N_EXT;
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_id    = scan_idx;
            end
        end
    end

    always_comb begin
        next_ptr   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
        holder_req = req[gnt_id_q];
        others_req = |(req & ~gnt_q);
        revoke     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM) && others_req;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    gnt_d         = '0;
                    gnt_d[sel_id] = 1'b1;
                    gnt_id_d      = sel_id;
                    gnt_valid_d   = 1'b1;
                    hold_cnt_d    = 8'd1;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                // Release and timeout share one path, so a simultaneous pair is harmless.
                if (!holder_req || revoke) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = next_ptr;
                    hold_cnt_d  = '0;
                    state_d     = IDLE;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: one instance with MAX_HOLD=16, one with MAX_HOLD=4,
// expectations queued at drive time and compared one cycle later.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       reset_n;
    logic [7:0] req16, req4;
    logic [7:0] gnt16, gnt4;
    logic       valid16, valid4;
    logic [2:0] id16, id4;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] g16;
        logic [2:0] i16;
        logic       v16;
        logic [7:0] g4;
        logic [2:0] i4;
        logic       v4;
    } exp_t;

    exp_t sb[$];
    logic [2:0] last_id16 = 3'd0;
    logic [2:0] last_id4  = 3'd0;

    rr_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .req(req16),
        .gnt(gnt16), .gnt_valid(valid16), .gnt_id(id16)
    );

    rr_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .req(req4),
        .gnt(gnt4), .gnt_valid(valid4), .gnt_id(id4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] onehot_index(input logic [7:0] v, input logic [2:0] prev);
        logic [2:0] r;
        r = prev;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic push_expect(input logic [7:0] e16, input logic [7:0] e4);
        exp_t e;
        last_id16 = onehot_index(e16, last_id16);
        last_id4  = onehot_index(e4, last_id4);
        e.g16 = e16;  e.i16 = last_id16;  e.v16 = |e16;
        e.g4  = e4;   e.i4  = last_id4;   e.v4  = |e4;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) passed++;
        else begin
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        cmp({tag, ".gnt16"},   gnt16,         e.g16);
        cmp({tag, ".id16"},    {5'd0, id16},  {5'd0, e.i16});
        cmp({tag, ".valid16"}, {7'd0, valid16}, {7'd0, e.v16});
        cmp({tag, ".gnt4"},    gnt4,          e.g4);
        cmp({tag, ".id4"},     {5'd0, id4},   {5'd0, e.i4});
        cmp({tag, ".valid4"},  {7'd0, valid4}, {7'd0, e.v4});
    endtask

    task automatic apply_stimulus(input string tag, input logic [7:0] r16, input logic [7:0] r4,
                                  input logic [7:0] e16, input logic [7:0] e4);
        req16 = r16;
        req4  = r4;
        push_expect(e16, e4);
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        req16   = 8'h00;
        req4    = 8'h00;
        #2;
        push_expect(8'h00, 8'h00);
        check_output("reset");
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Rotating priority start point and hold with MAX_HOLD=16.
        apply_stimulus("first_grant", 8'h06, 8'h00, 8'h02, 8'h00);
        for (int c = 0; c < 5; c++) apply_stimulus("hold16", 8'h06, 8'h00, 8'h02, 8'h00);
        apply_stimulus("release_gap", 8'h04, 8'h00, 8'h00, 8'h00);
        apply_stimulus("next_grant", 8'h04, 8'h00, 8'h04, 8'h00);
        apply_stimulus("drop16", 8'h00, 8'h00, 8'h00, 8'h00);

        // Full contention with MAX_HOLD=4: four cycles each, one gap, in index order.
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 4; c++) begin
                apply_stimulus("rotate_hold", 8'h00, 8'hFF, 8'h00, 8'h01 << (g % 8));
            end
            apply_stimulus("rotate_gap", 8'h00, 8'hFF, 8'h00, 8'h00);
        end

        // Wrap-around: ptr=7 makes index 7 beat index 0.
        apply_stimulus("grant6", 8'h00, 8'h40, 8'h00, 8'h40);
        apply_stimulus("release6", 8'h00, 8'h00, 8'h00, 8'h00);
        apply_stimulus("wrap_7_wins", 8'h00, 8'h81, 8'h00, 8'h80);
        apply_stimulus("release7", 8'h00, 8'h01, 8'h00, 8'h00);
        apply_stimulus("wrap_then_0", 8'h00, 8'h01, 8'h00, 8'h01);
        apply_stimulus("release0", 8'h00, 8'h00, 8'h00, 8'h00);

        // Sole requester is never revoked.
        for (int c = 0; c < 40; c++) apply_stimulus("sole_hold", 8'h00, 8'h20, 8'h00, 8'h20);

        // Asynchronous reset in the middle of a grant.
        #2 reset_n = 1'b0;
        #1;
        last_id16 = 3'd0;
        last_id4  = 3'd0;
        push_expect(8'h00, 8'h00);
        check_output("async_reset");
        req16 = 8'h00;
        req4  = 8'h00;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus("post_reset", 8'h3F, 8'h3F, 8'h01, 8'h01);
        apply_stimulus("post_reset_drop", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
